t07_spi_rx: RTL and testbench

//  SPI target-side receiver: the receiving end of the t07 TFT SPI link (sclk/chipSelect/bitData).

---
 rtl/t07_spi_pkg.sv | 13 +
 rtl/t07_spi_rx_if.sv | 27 ++
 rtl/t07_spi_rx_fifo.sv | 62 ++++++
 rtl/t07_spi_rx.sv | 146 ++++++++++++++
 tb/tb_t07_spi_rx.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/t07_spi_pkg.sv
// Shared definitions for the t07 SPI link (transmitter and receiver).
// Word width and queue depth defaults, plus the receiver frame-state encoding.
package t07_spi_pkg;

    localparam int WORD_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        IDLE,
        ACTIVE
    } t07_spi_rx_state_t;

endpackage

// File: rtl/t07_spi_rx_if.sv
// Received-word stream between the SPI receiver (master) and its consumer (slave).
// Carries the FIFO head word, its valid/ready handshake and the current fill level.
interface t07_spi_rx_if #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
);

    logic [WORD_W-1:0]            word_out;
    logic                         word_valid;
    logic                         word_ready;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    modport master (
        output word_out,
        output word_valid,
        output fifo_count,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        input  fifo_count,
        output word_ready
    );

endinterface

// File: rtl/t07_spi_rx_fifo.sv
// First-word fall-through queue for received words.
// A push into a full queue is accepted only when a pop frees a slot in the same cycle; otherwise drop pulses.
module t07_spi_rx_fifo #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WORD_W-1:0]             din,
    output logic                          full,
    input  logic                          pop,
    output logic [WORD_W-1:0]             dout,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign dout    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; dout is masked while empty so stale entries never reach the port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/t07_spi_rx.sv
// SPI mode-0 target receiver: oversamples sclk/cs_n/sdata on clk, assembles MSB-first words
// and queues them behind a valid/ready stream, with sticky overflow and frame-error flags.
module t07_spi_rx
    import t07_spi_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         cs_n,
    input  logic         sdata,
    input  logic         clr_err,
    output logic         busy,
    output logic         overflow,
    output logic         frame_err,
    t07_spi_rx_if.master stream
);

    localparam int BIT_W = $clog2(WORD_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   sdata_s;
    logic                   sclk_rise;
    logic                   cs_rise;
    logic                   cs_fall;

    t07_spi_rx_state_t      state;
    logic [WORD_W-2:0]      shift;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   push_q;
    logic [WORD_W-1:0]      din_q;

    logic                   drop;
    logic                   fifo_empty;
    logic                   fifo_full_unused;
    logic [WORD_W-1:0]      head;
    logic [CNT_W-1:0]       count;

    // cs_n synchronizes to its idle level so reset release cannot fake a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            sdata_sync <= '0;
            sclk_prev  <= 1'b0;
            cs_prev    <= 1'b1;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata};
            sclk_prev  <= sclk_sync[SYNC_STAGES-1];
            cs_prev    <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            push_q    <= 1'b0;
            din_q     <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // NOTE: non-blocking throughout, so the error events further down override the clr_err clear.
            if (clr_err) begin
                frame_err <= 1'b0;
                overflow  <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= ACTIVE;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ACTIVE: begin
                    // cs_n rising takes priority over a coincident sclk edge.
                    if (cs_rise) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shift <= {shift[WORD_W-3:0], sdata_s};
                        if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                            push_q  <= 1'b1;
                            din_q   <= {shift, sdata_s};
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    t07_spi_rx_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .din   (din_q),
        .full  (fifo_full_unused),
        .pop   (stream.word_ready),
        .dout  (head),
        .empty (fifo_empty),
        .count (count),
        .drop  (drop)
    );

    assign stream.word_out   = head;
    assign stream.word_valid = ~fifo_empty;
    assign stream.fifo_count = count;

endmodule

// File: tb/tb_t07_spi_rx.sv
// Bench for t07_spi_rx: a pin-level frame model with fixed pipeline delays predicts every output
// each cycle, and directed scenarios pin the model with hand-computed literal expectations.
module tb_t07_spi_rx;
    import t07_spi_pkg::*;

    localparam int W = WORD_W_DEF;
    localparam int D = FIFO_DEPTH_DEF;
    localparam int S = 2;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic sclk    = 1'b0;
    logic cs_n    = 1'b1;
    logic sdata   = 1'b0;
    logic clr_err = 1'b0;
    logic busy;
    logic overflow;
    logic frame_err;

    t07_spi_rx_if #(.WORD_W(W), .FIFO_DEPTH(D)) stream ();

    t07_spi_rx #(
        .WORD_W      (W),
        .FIFO_DEPTH  (D),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .sdata     (sdata),
        .clr_err   (clr_err),
        .busy      (busy),
        .overflow  (overflow),
        .frame_err (frame_err),
        .stream    (stream)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the queue content, sticky flags and frame state as seen from the pins.
    // A pin change seen at edge n reaches the frame logic at edge n+S; a completed word lands at n+S+1.
    logic [W-1:0] q [$];
    logic [W-1:0] arr_at [int];
    bit           ferr_at [int];
    bit           busy_at [int];
    bit           ov_m, fe_m, busy_m;
    bit           in_frame, sclk_seen, cs_seen, ov_ev;
    int           nbits, now;
    logic [W-1:0] cur;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            arr_at.delete();
            ferr_at.delete();
            busy_at.delete();
            ov_m      = 1'b0;
            fe_m      = 1'b0;
            busy_m    = 1'b0;
            in_frame  = 1'b0;
            nbits     = 0;
            cur       = '0;
            sclk_seen = 1'b0;
            cs_seen   = 1'b1;
        end else begin
            now   = cyc + 1;
            ov_ev = 1'b0;
            if (stream.word_ready && q.size() > 0) void'(q.pop_front());
            if (arr_at.exists(now)) begin
                if (q.size() < D) q.push_back(arr_at[now]);
                else ov_ev = 1'b1;
            end
            ov_m = ov_ev || (ov_m && !clr_err);
            fe_m = ferr_at.exists(now) || (fe_m && !clr_err);
            if (busy_at.exists(now)) busy_m = busy_at[now];

            if (!in_frame && cs_seen && !cs_n) begin
                in_frame = 1'b1;
                nbits    = 0;
                busy_at[now + S] = 1'b1;
            end else if (in_frame && !cs_seen && cs_n) begin
                in_frame = 1'b0;
                if (nbits != 0) ferr_at[now + S] = 1'b1;
                busy_at[now + S] = 1'b0;
            end else if (in_frame && !sclk_seen && sclk) begin
                cur = {cur[W-2:0], sdata};
                nbits++;
                if (nbits == W) begin
                    arr_at[now + S + 1] = cur;
                    nbits = 0;
                end
            end
            sclk_seen = sclk;
            cs_seen   = cs_n;
        end
    end

    always @(negedge clk) begin
        check("word_valid", 32'(stream.word_valid), 32'(q.size() > 0));
        check("fifo_count", 32'(stream.fifo_count), 32'(q.size()));
        if (q.size() > 0) check("word_out", 32'(stream.word_out), 32'(q[0]));
        check("busy", 32'(busy), 32'(busy_m));
        check("overflow", 32'(overflow), 32'(ov_m));
        check("frame_err", 32'(frame_err), 32'(fe_m));
    end

    int  last_valid_rise = -1;
    bit  prev_valid      = 1'b0;
    always @(negedge clk) begin
        if (stream.word_valid && !prev_valid) last_valid_rise = cyc;
        prev_valid = stream.word_valid;
    end

    int last_rise = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit pulse_ready = 1'b0, input bit pulse_clr = 1'b0);
        sdata = b;
        tick(4);
        sclk      = 1'b1;
        last_rise = cyc;
        if (pulse_ready || pulse_clr) begin
            tick(3);
            stream.word_ready = pulse_ready;
            clr_err           = pulse_clr;
            tick(1);
            stream.word_ready = 1'b0;
            clr_err           = 1'b0;
        end else begin
            tick(4);
        end
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit pulse_ready = 1'b0, input bit pulse_clr = 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], pulse_ready && (i == 0), pulse_clr && (i == 0));
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        tick(2);
    endtask

    task automatic cs_high();
        tick(4);
        cs_n = 1'b1;
        tick(6);
    endtask

    task automatic pop_check(input string name, input logic [W-1:0] exp);
        stream.word_ready = 1'b1;
        @(negedge clk);
        check({name, "_valid"}, 32'(stream.word_valid), 32'd1);
        check(name, 32'(stream.word_out), 32'(exp));
        tick(1);
        stream.word_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
    endtask

    task automatic check_idle_zero(input string name);
        @(negedge clk);
        check({name, "_word_out"},   32'(stream.word_out),   32'd0);
        check({name, "_word_valid"}, 32'(stream.word_valid), 32'd0);
        check({name, "_fifo_count"}, 32'(stream.fifo_count), 32'd0);
        check({name, "_busy"},       32'(busy),              32'd0);
        check({name, "_overflow"},   32'(overflow),          32'd0);
        check({name, "_frame_err"},  32'(frame_err),         32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] partial;
        stream.word_ready = 1'b0;

        // 1: pins toggle under reset, then sclk toggles with cs_n held high.
        tick(1);
        for (int i = 0; i < 5; i++) begin
            sclk  = ~sclk;
            cs_n  = ~cs_n;
            sdata = ~sdata;
            tick(1);
        end
        check_idle_zero("reset");
        sclk  = 1'b0;
        cs_n  = 1'b1;
        sdata = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
            tick(4);
        end
        check_idle_zero("no_cs");

        // 2: single word, exact arrival latency.
        cs_low();
        send_word(16'hA5C3);
        tick(1);
        @(negedge clk);
        check("latency", 32'(last_valid_rise - last_rise), 32'(S + 2));
        check("a5c3_word", 32'(stream.word_out), 32'h0000_A5C3);
        check("a5c3_count", 32'(stream.fifo_count), 32'd1);
        cs_high();
        @(negedge clk);
        check("a5c3_frame_err", 32'(frame_err), 32'd0);
        tick(1);
        pop_check("a5c3_pop", 16'hA5C3);
        @(negedge clk);
        check("a5c3_empty", 32'(stream.word_valid), 32'd0);
        tick(1);

        // 3: five words with no consumer; the fifth is dropped.
        cs_low();
        for (int k = 1; k <= 5; k++) send_word(W'(k));
        cs_high();
        @(negedge clk);
        check("ovf_count", 32'(stream.fifo_count), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        tick(1);
        pop_check("ovf_pop1", 16'h0001);
        pop_check("ovf_pop2", 16'h0002);
        pop_check("ovf_pop3", 16'h0003);
        pop_check("ovf_pop4", 16'h0004);
        @(negedge clk);
        check("ovf_drained", 32'(stream.word_valid), 32'd0);
        tick(1);
        pulse_clr();
        @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'd0);
        tick(1);

        // 4: partial frame of 9 bits, then a clean frame.
        partial = 9'h16B;
        cs_low();
        for (int i = 8; i >= 0; i--) send_bit(partial[i]);
        cs_high();
        @(negedge clk);
        check("ferr_flag", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(stream.fifo_count), 32'd0);
        tick(1);
        pulse_clr();
        @(negedge clk);
        check("ferr_cleared", 32'(frame_err), 32'd0);
        tick(1);
        cs_low();
        send_word(16'h1234);
        cs_high();
        pop_check("after_ferr", 16'h1234);

        // 5: full queue with a coincident pop, then drops with and without clr_err.
        cs_low();
        send_word(16'h1111);
        send_word(16'h2222);
        send_word(16'h3333);
        send_word(16'h4444);
        send_word(16'h5555, 1'b1, 1'b0);
        @(negedge clk);
        check("full_pop_count", 32'(stream.fifo_count), 32'd4);
        check("full_pop_ovf", 32'(overflow), 32'd0);
        tick(1);
        send_word(16'h6666);
        @(negedge clk);
        check("drop_ovf", 32'(overflow), 32'd1);
        tick(1);
        send_word(16'h7777, 1'b0, 1'b1);
        tick(1);
        @(negedge clk);
        check("clr_vs_drop_ovf", 32'(overflow), 32'd1);
        cs_high();
        pop_check("tail_pop1", 16'h2222);
        pop_check("tail_pop2", 16'h3333);
        pop_check("tail_pop3", 16'h4444);
        pop_check("tail_pop4", 16'h5555);
        @(negedge clk);
        check("tail_drained", 32'(stream.word_valid), 32'd0);
        tick(1);
        pulse_clr();

        // 6: reset in the middle of a frame, then a fresh frame.
        cs_low();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        reset = 1'b1;
        cs_n  = 1'b1;
        sdata = 1'b0;
        tick(1);
        check_idle_zero("mid_reset");
        tick(1);
        reset = 1'b0;
        tick(3);
        cs_low();
        send_word(16'h8001);
        cs_high();
        @(negedge clk);
        check("post_reset_count", 32'(stream.fifo_count), 32'd1);
        check("post_reset_ferr", 32'(frame_err), 32'd0);
        tick(1);
        pop_check("post_reset_word", 16'h8001);
        @(negedge clk);
        check("post_reset_empty", 32'(stream.word_valid), 32'd0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
